// File: rtl/reduce_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reduce_pkg                                                |
// | Purpose  : Shared constants and helpers for the reduction tree.      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
package reduce_pkg;

  localparam logic MODE_SUM = 1'b0;
  localparam logic MODE_MAX = 1'b1;

  // Helpers operate on a wide container; callers take the low bits they need.
  localparam int FN_W = 64;

  typedef struct packed {
    logic [FN_W-1:0] sum;
    logic            ovf;
  } sat_res_t;

  // Identity element of the reduction: 0 for SUM, most negative value for MAX.
  // The result is sign-extended to FN_W bits.
  function automatic logic [FN_W-1:0] identity(input logic mode, input int width);
    logic [FN_W-1:0] r;
    r = '0;
    if (mode == MODE_MAX) begin
      r = {FN_W{1'b1}} << (width - 1);
    end
    return r;
  endfunction

  // Signed add of two sign-extended width-bit values, clipped to the signed
  // width-bit range. ovf reports that clipping took place.
  function automatic sat_res_t sat_add(input logic [FN_W-1:0] a,
                                       input logic [FN_W-1:0] b,
                                       input int              width);
    logic signed [FN_W-1:0] s;
    logic signed [FN_W-1:0] hi;
    logic signed [FN_W-1:0] lo;
    sat_res_t               r;
    s  = $signed(a) + $signed(b);
    lo = $signed({FN_W{1'b1}} << (width - 1));
    hi = ~lo;
    r.sum = s;
    r.ovf = 1'b0;
    if (s > hi) begin
      r.sum = hi;
      r.ovf = 1'b1;
    end else if (s < lo) begin
      r.sum = lo;
      r.ovf = 1'b1;
    end
    return r;
  endfunction

  // Number of pairwise tree levels needed for n lanes (ceil(log2(n))).
  function automatic int num_stages(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) begin
        r = i + 1;
      end
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/reduce_tree_pipe_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reduce_tree_pipe_if                                       |
// | Purpose  : Input beat and output result handshake bundle.            |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
interface reduce_tree_pipe_if #(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 8
);

  logic                             in_valid;
  logic                             in_ready;
  logic [NUM_INPUTS*DATA_WIDTH-1:0] in_data;
  logic [NUM_INPUTS-1:0]            in_mask;
  logic                             in_mode;
  logic                             in_last;

  logic                             out_valid;
  logic                             out_ready;
  logic [ACC_WIDTH-1:0]             out_data;
  logic                             out_mode;
  logic                             out_sat;

  // Producer of beats / consumer of results
  modport master (
    output in_valid, in_data, in_mask, in_mode, in_last, out_ready,
    input  in_ready, out_valid, out_data, out_mode, out_sat
  );

  // The reduction tree itself
  modport slave (
    input  in_valid, in_data, in_mask, in_mode, in_last, out_ready,
    output in_ready, out_valid, out_data, out_mode, out_sat
  );

endinterface
`default_nettype wire

// File: rtl/reduce_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reduce_stage                                              |
// | Purpose  : One registered tree level: pairs lane 2j with 2j+1 and    |
// |            carries the beat sideband alongside.                      |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module reduce_stage
  import reduce_pkg::*;
#(
  parameter int N_IN      = 2,
  parameter int ACC_WIDTH = 24
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            en_i,
  input  logic                            valid_i,
  input  logic                            mode_i,
  input  logic                            first_i,
  input  logic                            last_i,
  input  logic [N_IN*ACC_WIDTH-1:0]       data_i,
  output logic                            valid_o,
  output logic                            mode_o,
  output logic                            first_o,
  output logic                            last_o,
  output logic [(N_IN/2)*ACC_WIDTH-1:0]   data_o
);

  localparam int N_OUT = N_IN / 2;

  logic [N_OUT*ACC_WIDTH-1:0] w_comb;
  logic [N_OUT*ACC_WIDTH-1:0] r_data_q,  r_data_d;
  logic                       r_valid_q, r_valid_d;
  logic                       r_mode_q,  r_mode_d;
  logic                       r_first_q, r_first_d;
  logic                       r_last_q,  r_last_d;

  // Pairwise combine; the accumulator width leaves headroom so SUM never wraps
  for (genvar j = 0; j < N_OUT; j++) begin : g_pair
    logic signed [ACC_WIDTH-1:0] w_a;
    logic signed [ACC_WIDTH-1:0] w_b;
    assign w_a = data_i[(2*j)*ACC_WIDTH +: ACC_WIDTH];
    assign w_b = data_i[(2*j+1)*ACC_WIDTH +: ACC_WIDTH];
    assign w_comb[j*ACC_WIDTH +: ACC_WIDTH] =
      (mode_i == MODE_SUM) ? (w_a + w_b) : ((w_a > w_b) ? w_a : w_b);
  end

  // Advance the level only when the pipeline is not stalled
  always_comb begin
    r_data_d  = r_data_q;
    r_valid_d = r_valid_q;
    r_mode_d  = r_mode_q;
    r_first_d = r_first_q;
    r_last_d  = r_last_q;
    if (en_i) begin
      r_data_d  = w_comb;
      r_valid_d = valid_i;
      r_mode_d  = mode_i;
      r_first_d = first_i;
      r_last_d  = last_i;
    end
  end

  // Level registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_data_q  <= '0;
      r_valid_q <= 1'b0;
      r_mode_q  <= 1'b0;
      r_first_q <= 1'b0;
      r_last_q  <= 1'b0;
    end else begin
      r_data_q  <= r_data_d;
      r_valid_q <= r_valid_d;
      r_mode_q  <= r_mode_d;
      r_first_q <= r_first_d;
      r_last_q  <= r_last_d;
    end
  end

  assign data_o  = r_data_q;
  assign valid_o = r_valid_q;
  assign mode_o  = r_mode_q;
  assign first_o = r_first_q;
  assign last_o  = r_last_q;

endmodule
`default_nettype wire

// File: rtl/reduce_tree_pipe.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : reduce_tree_pipe                                          |
// | Purpose  : Pipelined SUM/MAX reduction tree with multi-beat          |
// |            accumulation and valid/ready handshakes on both sides.    |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module reduce_tree_pipe
  import reduce_pkg::*;
#(
  parameter int NUM_INPUTS = 8,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = DATA_WIDTH + 8
) (
  input  logic               clk,
  input  logic               rst_n,
  reduce_tree_pipe_if.slave  io
);

  localparam int NUM_STAGES = num_stages(NUM_INPUTS);
  localparam int PAD_LANES  = 1 << NUM_STAGES;
  // All tree levels packed back to back: PAD, PAD/2, ..., 1 lanes
  localparam int TREE_LANES = 2 * PAD_LANES - 1;

  logic w_stall;
  logic w_advance;
  logic w_accept;
  logic w_beat_mode;

  logic r_first_q, r_first_d;
  logic r_mode_q,  r_mode_d;

  logic [FN_W-1:0]                 w_ident_full;
  logic [ACC_WIDTH-1:0]            w_ident;
  logic [TREE_LANES*ACC_WIDTH-1:0] w_tree_data;
  logic [NUM_STAGES:0]             w_lvl_valid;
  logic [NUM_STAGES:0]             w_lvl_mode;
  logic [NUM_STAGES:0]             w_lvl_first;
  logic [NUM_STAGES:0]             w_lvl_last;

  logic signed [ACC_WIDTH-1:0]     w_root;
  logic [FN_W-1:0]                 w_acc_ext;
  logic [FN_W-1:0]                 w_root_ext;
  sat_res_t                        w_sat_res;
  logic                            w_unused_bits;

  logic signed [ACC_WIDTH-1:0]     r_acc_q, r_acc_d;
  logic                            r_sat_q, r_sat_d;
  logic                            r_acc_valid_q, r_acc_valid_d;
  logic                            r_acc_last_q,  r_acc_last_d;
  logic                            r_acc_mode_q,  r_acc_mode_d;

  logic [ACC_WIDTH-1:0]            r_out_data_q,  r_out_data_d;
  logic                            r_out_valid_q, r_out_valid_d;
  logic                            r_out_mode_q,  r_out_mode_d;
  logic                            r_out_sat_q,   r_out_sat_d;

  // ---------------------------------------------------------------------
  // Handshake
  // ---------------------------------------------------------------------
  assign w_stall     = r_out_valid_q && !io.out_ready;
  assign w_advance   = !w_stall;
  assign io.in_ready = w_advance && rst_n;
  assign w_accept    = io.in_valid && io.in_ready;

  // Mode is taken from the first beat of a vector and held until its last
  assign w_beat_mode = r_first_q ? io.in_mode : r_mode_q;

  // Track vector boundaries and the latched mode
  always_comb begin
    r_first_d = r_first_q;
    r_mode_d  = r_mode_q;
    if (w_accept) begin
      r_first_d = io.in_last;
      r_mode_d  = w_beat_mode;
    end
  end

  // Vector-boundary tracker; reset starts a fresh vector
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_first_q <= 1'b1;
      r_mode_q  <= MODE_SUM;
    end else begin
      r_first_q <= r_first_d;
      r_mode_q  <= r_mode_d;
    end
  end

  // ---------------------------------------------------------------------
  // Tree input: sign extension, masking and padding to a power of two
  // ---------------------------------------------------------------------
  assign w_ident_full = identity(w_beat_mode, DATA_WIDTH);
  assign w_ident      = w_ident_full[ACC_WIDTH-1:0];

  for (genvar i = 0; i < PAD_LANES; i++) begin : g_lane
    if (i < NUM_INPUTS) begin : g_real
      assign w_tree_data[i*ACC_WIDTH +: ACC_WIDTH] = io.in_mask[i] ?
        {{(ACC_WIDTH-DATA_WIDTH){io.in_data[(i+1)*DATA_WIDTH-1]}},
         io.in_data[i*DATA_WIDTH +: DATA_WIDTH]} : w_ident;
    end else begin : g_pad
      assign w_tree_data[i*ACC_WIDTH +: ACC_WIDTH] = w_ident;
    end
  end

  assign w_lvl_valid[0] = w_accept;
  assign w_lvl_mode[0]  = w_beat_mode;
  assign w_lvl_first[0] = r_first_q;
  assign w_lvl_last[0]  = io.in_last;

  // ---------------------------------------------------------------------
  // Registered tree levels
  // ---------------------------------------------------------------------
  for (genvar s = 0; s < NUM_STAGES; s++) begin : g_stage
    localparam int N_IN    = PAD_LANES >> s;
    localparam int OFF_IN  = 2 * PAD_LANES - 2 * N_IN;
    localparam int OFF_OUT = 2 * PAD_LANES - N_IN;

    reduce_stage #(
      .N_IN      (N_IN),
      .ACC_WIDTH (ACC_WIDTH)
    ) u_stage (
      .clk     (clk),
      .rst_n   (rst_n),
      .en_i    (w_advance),
      .valid_i (w_lvl_valid[s]),
      .mode_i  (w_lvl_mode[s]),
      .first_i (w_lvl_first[s]),
      .last_i  (w_lvl_last[s]),
      .data_i  (w_tree_data[OFF_IN*ACC_WIDTH +: N_IN*ACC_WIDTH]),
      .valid_o (w_lvl_valid[s+1]),
      .mode_o  (w_lvl_mode[s+1]),
      .first_o (w_lvl_first[s+1]),
      .last_o  (w_lvl_last[s+1]),
      .data_o  (w_tree_data[OFF_OUT*ACC_WIDTH +: (N_IN/2)*ACC_WIDTH])
    );
  end

  // ---------------------------------------------------------------------
  // Accumulate stage
  // ---------------------------------------------------------------------
  assign w_root     = w_tree_data[(TREE_LANES-1)*ACC_WIDTH +: ACC_WIDTH];
  assign w_acc_ext  = {{(FN_W-ACC_WIDTH){r_acc_q[ACC_WIDTH-1]}}, r_acc_q};
  assign w_root_ext = {{(FN_W-ACC_WIDTH){w_root[ACC_WIDTH-1]}}, w_root};
  assign w_sat_res  = sat_add(w_acc_ext, w_root_ext, ACC_WIDTH);

  // Only the low ACC_WIDTH bits of the wide helper results are meaningful
  assign w_unused_bits = ^{w_ident_full[FN_W-1:ACC_WIDTH],
                           w_sat_res.sum[FN_W-1:ACC_WIDTH]};

  // Fold each tree result into the running vector value
  always_comb begin
    r_acc_d       = r_acc_q;
    r_sat_d       = r_sat_q;
    r_acc_valid_d = r_acc_valid_q;
    r_acc_last_d  = r_acc_last_q;
    r_acc_mode_d  = r_acc_mode_q;
    if (w_advance) begin
      r_acc_valid_d = w_lvl_valid[NUM_STAGES];
      r_acc_last_d  = w_lvl_last[NUM_STAGES];
      r_acc_mode_d  = w_lvl_mode[NUM_STAGES];
      if (w_lvl_valid[NUM_STAGES]) begin
        if (w_lvl_first[NUM_STAGES]) begin
          r_acc_d = w_root;
          r_sat_d = 1'b0;
        end else if (w_lvl_mode[NUM_STAGES] == MODE_SUM) begin
          r_acc_d = w_sat_res.sum[ACC_WIDTH-1:0];
          r_sat_d = r_sat_q | w_sat_res.ovf;
        end else if (w_root > r_acc_q) begin
          r_acc_d = w_root;
        end
      end
    end
  end

  // Accumulator registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_acc_q       <= '0;
      r_sat_q       <= 1'b0;
      r_acc_valid_q <= 1'b0;
      r_acc_last_q  <= 1'b0;
      r_acc_mode_q  <= MODE_SUM;
    end else begin
      r_acc_q       <= r_acc_d;
      r_sat_q       <= r_sat_d;
      r_acc_valid_q <= r_acc_valid_d;
      r_acc_last_q  <= r_acc_last_d;
      r_acc_mode_q  <= r_acc_mode_d;
    end
  end

  // ---------------------------------------------------------------------
  // Output register
  // ---------------------------------------------------------------------
  // Not stalled means the slot is empty or being consumed this cycle, so
  // a completed vector may always be loaded then.
  always_comb begin
    r_out_data_d  = r_out_data_q;
    r_out_valid_d = r_out_valid_q;
    r_out_mode_d  = r_out_mode_q;
    r_out_sat_d   = r_out_sat_q;
    if (w_advance) begin
      r_out_valid_d = r_acc_valid_q && r_acc_last_q;
      if (r_acc_valid_q && r_acc_last_q) begin
        r_out_data_d = r_acc_q;
        r_out_mode_d = r_acc_mode_q;
        r_out_sat_d  = r_sat_q;
      end
    end
  end

  // Result registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_out_data_q  <= '0;
      r_out_valid_q <= 1'b0;
      r_out_mode_q  <= MODE_SUM;
      r_out_sat_q   <= 1'b0;
    end else begin
      r_out_data_q  <= r_out_data_d;
      r_out_valid_q <= r_out_valid_d;
      r_out_mode_q  <= r_out_mode_d;
      r_out_sat_q   <= r_out_sat_d;
    end
  end

  assign io.out_valid = r_out_valid_q;
  assign io.out_data  = r_out_data_q;
  assign io.out_mode  = r_out_mode_q;
  assign io.out_sat   = r_out_sat_q;

endmodule
`default_nettype wire

// File: tb/tb_reduce_tree_pipe.sv
`timescale 1ns/1ps
`default_nettype none
// +----------------------------------------------------------------------+
// | Module   : tb_reduce_tree_pipe                                       |
// | Purpose  : Self-checking bench for reduce_tree_pipe (4 and 5 lanes). |
// | Revision : 1.0 - initial release                                     |
// +----------------------------------------------------------------------+
module tb_reduce_tree_pipe;

  localparam int NI = 4;
  localparam int DW = 8;
  localparam int AW = 12;
  localparam int ACC_MAX = 2047;
  localparam int ACC_MIN = -2048;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  reduce_tree_pipe_if #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();
  reduce_tree_pipe #(.NUM_INPUTS(NI), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus)
  );

  reduce_tree_pipe_if #(.NUM_INPUTS(5), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus5 ();
  reduce_tree_pipe #(.NUM_INPUTS(5), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) dut5 (
    .clk   (clk),
    .rst_n (rst_n),
    .io    (bus5)
  );

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    logic [AW-1:0] data;
    logic          mode;
    logic          sat;
  } res_t;

  res_t exp_q[$];
  res_t mon_e;

  // Reference model state: one vector in progress
  bit   m_first = 1'b1;
  logic m_mode  = 1'b0;
  int   m_acc   = 0;
  bit   m_sat   = 1'b0;

  bit   rnd_bp  = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] pack4(input int a, input int b, input int c, input int d);
    return {d[7:0], c[7:0], b[7:0], a[7:0]};
  endfunction

  // Reduce one beat directly from its lane values
  function automatic int beat_val(input logic [31:0] d, input logic [3:0] m, input logic mode);
    int r;
    int v;
    r = mode ? -128 : 0;
    for (int i = 0; i < 4; i++) begin
      if (m[i]) begin
        v = int'($signed(d[i*8 +: 8]));
        if (mode) r = (v > r) ? v : r;
        else      r = r + v;
      end
    end
    return r;
  endfunction

  task automatic model_accept(input logic [31:0] d, input logic [3:0] m,
                              input logic mode, input logic last);
    logic md;
    int   bv;
    md = m_first ? mode : m_mode;
    bv = beat_val(d, m, md);
    if (m_first) begin
      m_acc = bv;
      m_sat = 1'b0;
    end else if (md == 1'b0) begin
      m_acc = m_acc + bv;
      if (m_acc > ACC_MAX) begin m_acc = ACC_MAX; m_sat = 1'b1; end
      else if (m_acc < ACC_MIN) begin m_acc = ACC_MIN; m_sat = 1'b1; end
    end else if (bv > m_acc) begin
      m_acc = bv;
    end
    m_mode  = md;
    m_first = last;
    if (last) exp_q.push_back('{data: m_acc[AW-1:0], mode: md, sat: m_sat});
  endtask

  // Present one beat and wait (bounded) for it to be accepted
  task automatic send(input logic [31:0] d, input logic [3:0] m,
                      input logic mode, input logic last);
    bit done;
    done = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    bus.in_mask  = m;
    bus.in_mode  = mode;
    bus.in_last  = last;
    for (int k = 0; k < 1000 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
      @(posedge clk);
      #1;
    end
    bus.in_valid = 1'b0;
    check("send_accept", {31'd0, done}, 32'd1);
    if (done) model_accept(d, m, mode, last);
  endtask

  task automatic drain();
    for (int k = 0; k < 300; k++) begin
      if (exp_q.size() == 0 && !bus.out_valid) break;
      @(posedge clk);
      #1;
    end
    check("drain_empty", exp_q.size(), 0);
  endtask

  task automatic send5(input logic [39:0] d, input logic [4:0] m, input logic mode,
                       input logic [AW-1:0] exp, input string tag);
    bit acc;
    bit got;
    acc = 1'b0;
    got = 1'b0;
    bus5.in_valid = 1'b1;
    bus5.in_data  = d;
    bus5.in_mask  = m;
    bus5.in_mode  = mode;
    bus5.in_last  = 1'b1;
    for (int k = 0; k < 50 && !acc; k++) begin
      @(negedge clk);
      if (bus5.in_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    bus5.in_valid = 1'b0;
    for (int k = 0; k < 20 && !got; k++) begin
      @(negedge clk);
      if (bus5.out_valid) got = 1'b1;
      else begin @(posedge clk); #1; end
    end
    check({tag, "_valid"}, {31'd0, got}, 32'd1);
    check({tag, "_data"}, bus5.out_data, exp);
    check({tag, "_mode"}, bus5.out_mode, mode);
    @(posedge clk);
    #1;
  endtask

  // Scoreboard: every consumed result must match the next expected one
  always @(negedge clk) begin
    if (rst_n && bus.out_valid && bus.out_ready) begin
      check("result_expected", {31'd0, exp_q.size() != 0}, 32'd1);
      if (exp_q.size() != 0) begin
        mon_e = exp_q.pop_front();
        check("out_data", bus.out_data, mon_e.data);
        check("out_mode", bus.out_mode, mon_e.mode);
        check("out_sat",  bus.out_sat,  mon_e.sat);
      end
    end
  end

  // Random consumer backpressure
  initial begin
    forever begin
      @(posedge clk);
      #1;
      if (rnd_bp) bus.out_ready = ($urandom % 3) != 0;
    end
  end

  initial begin
    logic [31:0] rd;
    logic [3:0]  rm;
    int          nb;
    logic        vm;

    bus.in_valid = 1'b0;  bus.in_data = '0;  bus.in_mask = '1;
    bus.in_mode  = 1'b0;  bus.in_last = 1'b0; bus.out_ready = 1'b1;
    bus5.in_valid = 1'b0; bus5.in_data = '0; bus5.in_mask = '1;
    bus5.in_mode  = 1'b0; bus5.in_last = 1'b0; bus5.out_ready = 1'b1;

    // Reset state
    rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready",  bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_out_data",  bus.out_data, 0);
    check("rst_out_mode",  bus.out_mode, 0);
    check("rst_out_sat",   bus.out_sat, 0);
    rst_n = 1'b1;
    #1;
    check("post_rst_in_ready", bus.in_ready, 1);

    // SUM single beat and its latency
    send(pack4(1, 2, 3, 4), 4'hf, 1'b0, 1'b1);
    repeat (2) @(posedge clk);
    #1;
    check("latency_early", bus.out_valid, 0);
    @(posedge clk);
    #1;
    check("latency_ontime", bus.out_valid, 1);
    drain();

    // Multi-beat SUM, then saturation, then sat flag cleared
    repeat (3) send(pack4(100, 100, 100, 100), 4'hf, 1'b0, 1'b0);
    exp_q.size();
    send(pack4(0, 0, 0, 0), 4'h0, 1'b1, 1'b1);
    for (int b = 0; b < 5; b++) send(pack4(127, 127, 127, 127), 4'hf, 1'b0, b == 4);
    send(pack4(1, 1, 1, 1), 4'hf, 1'b0, 1'b1);
    drain();

    // MAX across beats (later in_mode ignored), masked lane with minimum value
    send(pack4(-5, -3, -7, -128), 4'hf, 1'b1, 1'b0);
    send(pack4(-9, -2, -100, -50), 4'hf, 1'b0, 1'b1);
    send(pack4(-128, 100, 100, 100), 4'b0001, 1'b1, 1'b1);
    send(pack4(-20, -20, -20, -20), 4'b0000, 1'b0, 1'b1);
    drain();

    // Backpressure: results held, input blocked, order preserved
    bus.out_ready = 1'b0;
    send(pack4(1, 0, 0, 0), 4'hf, 1'b0, 1'b1);
    send(pack4(2, 0, 0, 0), 4'hf, 1'b0, 1'b1);
    send(pack4(3, -1, -2, 0), 4'hf, 1'b1, 1'b1);
    for (int k = 0; k < 20 && !bus.out_valid; k++) begin
      @(posedge clk);
      #1;
    end
    repeat (4) begin
      @(negedge clk);
      check("stall_in_ready",  bus.in_ready, 0);
      check("stall_out_valid", bus.out_valid, 1);
      check("stall_out_data",  bus.out_data, 1);
    end
    @(posedge clk);
    #1;
    bus.out_ready = 1'b1;
    drain();

    // Randomized vectors with random backpressure
    rnd_bp = 1'b1;
    for (int v = 0; v < 40; v++) begin
      nb = $urandom_range(1, 7);
      for (int b = 0; b < nb; b++) begin
        rd = $urandom;
        rm = (($urandom % 4) == 0) ? 4'($urandom) : 4'hf;
        vm = 1'($urandom);
        send(rd, rm, vm, b == nb - 1);
        if (($urandom % 4) == 0) begin
          @(posedge clk);
          #1;
        end
      end
    end
    rnd_bp = 1'b0;
    @(posedge clk);
    #2;
    bus.out_ready = 1'b1;
    drain();

    // Reset in the middle of a MAX vector, then a fresh SUM vector
    send(pack4(50, 50, 50, 50), 4'hf, 1'b1, 1'b0);
    send(pack4(60, 60, 60, 60), 4'hf, 1'b1, 1'b0);
    rst_n = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_last  = 1'b1;
    bus.in_data  = pack4(9, 9, 9, 9);
    #1;
    check("midrst_in_ready", bus.in_ready, 0);
    repeat (2) @(posedge clk);
    #1;
    check("midrst_out_valid", bus.out_valid, 0);
    bus.in_valid = 1'b0;
    rst_n = 1'b1;
    m_first = 1'b1;
    exp_q.delete();
    send(pack4(2, 2, 2, 2), 4'hf, 1'b0, 1'b1);
    drain();

    // Five-lane build: padding must not disturb SUM or MAX
    send5({5{8'h01}}, 5'h1f, 1'b0, 12'd5,   "n5_sum");
    send5({5{8'hff}}, 5'h1f, 1'b1, 12'hfff, "n5_max");
    send5({8'hf9, {4{8'd100}}}, 5'b10000, 1'b1, 12'hff9, "n5_lane4");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/reduce_tree_pipe.md
# reduce_tree_pipe

Pipelined, parametrised reduction tree for the softmax datapath. It replaces the combinational sum tree with a registered tree of arbitrary width that accumulates across multi-beat vectors. It runs in SUM mode (exponential denominator) or MAX mode (logit maximum for range reduction), selectable per vector. It sits between the output buffer and the softmax normaliser, with valid/ready handshakes on both sides.

## Interface
- NUM_INPUTS, 8: lanes per beat; any value ≥1, including non-powers of two
- DATA_WIDTH, 16: lane width, signed two's complement
- ACC_WIDTH, DATA_WIDTH+8: accumulator/result width, signed; must be ≥ DATA_WIDTH+$clog2(NUM_INPUTS)
- clk  in  1  sole clock, rising edge
- rst_n  in  1  synchronous, active-low reset
- in_valid  in  1  beat valid
- in_ready  out  1  beat accepted when in_valid && in_ready
- in_data  in  NUM_INPUTS*DATA_WIDTH  lane i at [(i+1)*DATA_WIDTH-1 : i*DATA_WIDTH]
- in_mask  in  NUM_INPUTS  1 = lane participates; 0 = lane replaced by the identity value
- in_mode  in  1  0 = SUM, 1 = MAX; sampled only on the first beat of a vector
- in_last  in  1  final beat of the vector
- out_valid  out  1  result valid
- out_ready  in  1  result consumed when out_valid && out_ready
- out_data  out  ACC_WIDTH  reduced result
- out_mode  out  1  mode the result was computed in
- out_sat  out  1  SUM saturated at some point during the vector

## Operation
- NUM_STAGES = $clog2(NUM_INPUTS). Lanes are padded to 2^NUM_STAGES with identity values: 0 for SUM, -2^(DATA_WIDTH-1) for MAX. Masked-off lanes also take the identity value.
- Each tree level combines adjacent pairs (lane 2j with lane 2j+1) and registers the result. Values are sign-extended to ACC_WIDTH at the tree input.
- Each beat carries valid, mode, first and last sideband through every stage. `first` is set on the first accepted beat after reset or after a beat with in_last. `mode` is latched from that first beat and held for the rest of the vector; in_mode on later beats is ignored.
- Accumulate stage:
  - first beat: acc := tree result.
  - otherwise, SUM: acc := sat(acc + tree), saturating to the signed ACC_WIDTH range; the sticky sat flag is set on any clip.
  - otherwise, MAX: acc := max(acc, tree), signed compare.
  - The sat flag clears on each first beat.
- When the last beat reaches the accumulate stage, the result is written to the output register (out_data, out_mode, out_sat) and out_valid is set. The accumulator is then free for the next vector in the following cycle.
- Backpressure: stall = out_valid && !out_ready. While stalled, all pipeline registers and the accumulator hold. in_ready = !stall && rst_n (combinational from out_ready).
- out_valid clears on handshake unless a new last beat completes in the same cycle, in which case the output is reloaded and out_valid stays 1.
- A single-beat vector (first and last on the same beat) is legal.
- NUM_INPUTS = 1: no tree registers; the beat enters the accumulate stage directly.

## Timing
- Reset (rst_n low at a clk edge): all stage valids 0; acc 0; out_valid 0, out_data 0, out_mode 0, out_sat 0; first-flag tracker set. in_ready is 0 while rst_n is low; beats presented then are dropped.
- Reset mid-vector discards the partial vector and any unconsumed result.
- Latency: a last beat accepted at edge t gives out_valid = 1 after edge t+NUM_STAGES+1, provided there are no stalls.
- Throughput: one beat per cycle when out_ready is held high.
- Stall cycles add latency one-for-one. No beat is lost or duplicated.

## Structure
- Package reduce_pkg holds:
  - MODE_SUM = 1'b0, MODE_MAX = 1'b1
  - function identity(mode, width)
  - function sat_add(a, b, width), returning sum and overflow flag
  - function num_stages(n)
- Sub-module reduce_stage: one tree level with N_IN lanes, N_IN/2 outputs, mode input, stall enable and sideband pass-through. It is instantiated NUM_STAGES times via generate.
- Top module contains input padding/masking, first-flag tracking, the accumulator and the output register.

## Test plan
All cases use NUM_INPUTS=4, DATA_WIDTH=8, ACC_WIDTH=12 (two tree stages) unless stated otherwise.
- SUM single beat [1,2,3,4], last=1, out_ready=1 → out_data=10, out_mode=0, out_valid after edge t+3.
- SUM three beats of [100,100,100,100] → 1200. Next vector [127,127,127,127]×5 → 2047 with out_sat=1. The vector after that has out_sat=0.
- MAX beats [-5,-3,-7,-128] then [-9,-2,-100,-50] → -2. Mask 4'b0001 with [-128,…] → -128.
- NUM_INPUTS=5 build, SUM [1,1,1,1,1] → 5; MAX [-1,-1,-1,-1,-1] → -1 (padding must not win).
- Back-to-back single-beat vectors with out_ready low for 4 cycles → in_ready low, the result held stable, no loss; the order of results is preserved after release.
- rst_n low mid-vector, then new vector [2,2,2,2] last → 8 with a fresh mode (in_mode at the first beat after reset honoured).
